multicycle_main_fsm: RTL and testbench

MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/instr_type_decoder.sv | 19 +
 rtl/multicycle_main_fsm.sv | 139 +++++++++++++
 tb/tb_multicycle_main_fsm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared control encodings for the multicycle RISC-V controller.
// The ERROR state exists only when ILLEGAL_TRAP_EN is defined.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
`ifdef ILLEGAL_TRAP_EN
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
`else
        S_JAL      = 4'd10
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_type_decoder.sv
// Immediate-format select, decoded purely from the latched opcode.
module instr_type_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of a multicycle RISC-V core with a memory handshake.
// Define ILLEGAL_TRAP_EN to add a sticky ERROR state and the illegal_instr output.
module multicycle_main_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic [1:0] imm_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
`ifdef ILLEGAL_TRAP_EN
    output logic       mem_write,
    output logic       illegal_instr
`else
    output logic       mem_write
`endif
);

    state_t r_state;
    state_t w_next;
    logic   w_pc_update;
    logic   w_branch;

    instr_type_decoder u_itd (
        .op      (op),
        .imm_src (imm_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        alu_op      = ALU_ADD;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        result_src  = RES_ALUOUT;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                // FETCH is the reset state, so its handshake enables must also see rst_n
                ir_write    = mem_ready & rst_n;
                w_pc_update = mem_ready & rst_n;
                w_next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           w_next = S_ERROR;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                w_next    = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = mem_ready;
                w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALU_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALU_SUB;
                w_branch  = 1'b1;
            end
            S_JAL: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_ERROR: begin
                illegal_instr = 1'b1;
                w_next        = S_ERROR;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    assign pc_write = w_pc_update | (w_branch & zero);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// schedule (handshake waits included) and compared against the DUT every cycle.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src, imm_src;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write;
    logic       ill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .imm_src    (imm_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
`ifdef ILLEGAL_TRAP_EN
        .mem_write  (mem_write),
        .illegal_instr (ill)
`else
        .mem_write  (mem_write)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign ill = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] alu_op, sa, sb, rs;
        logic       adr;
        logic [1:0] imm;
        logic       irw, pcw, rgw, mw, ill;
    } vec_t;

    // Instruction phases as the ISA-level description names them
    typedef enum {P_FETCH, P_DECODE, P_ADDR, P_READ, P_LOADWB, P_WRITE,
                  P_EXR, P_EXI, P_WB, P_BRANCH, P_JUMP, P_TRAP} phase_t;

    typedef struct {
        phase_t ph;
        logic   mr;
        logic   z;
    } step_t;

    step_t q[$];

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic vec_t expect_of(input phase_t ph, input logic [6:0] o,
                                       input logic mr, input logic z);
        vec_t e;
        e = '0;
        e.imm = imm_of(o);
        case (ph)
            P_FETCH:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
            P_DECODE: begin e.sa = 2'b01; e.sb = 2'b01; end
            P_ADDR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            P_READ:   e.adr = 1'b1;
            P_WRITE:  begin e.adr = 1'b1; e.mw = mr; end
            P_LOADWB: begin e.rs = 2'b01; e.rgw = 1'b1; end
            P_EXR:    begin e.sa = 2'b10; e.alu_op = 2'b10; end
            P_EXI:    begin e.sa = 2'b10; e.sb = 2'b01; e.alu_op = 2'b10; end
            P_WB:     e.rgw = 1'b1;
            P_BRANCH: begin e.sa = 2'b10; e.alu_op = 2'b01; e.pcw = z; end
            P_JUMP:   begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            P_TRAP:   e.ill = 1'b1;
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic vec_t observed();
        return {alu_op, alu_src_a, alu_src_b, result_src, adr_src, imm_src,
                ir_write, pc_write, reg_write, mem_write, ill};
    endfunction

    task automatic chk(input string tag, input vec_t act, input vec_t exp_v);
        checks++;
        assert (act === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp_v);
        end
    endtask

    task automatic push(input phase_t ph, input logic mr, input logic z);
        step_t s;
        s.ph = ph; s.mr = mr; s.z = z;
        q.push_back(s);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its cycle schedule; fw/mw are wait cycles
    task automatic build(input logic [6:0] o, input int fw, input int mw, input logic bz);
        q.delete();
        for (int i = 0; i < fw; i++) push(P_FETCH, 1'b0, rb());
        push(P_FETCH, 1'b1, rb());
        push(P_DECODE, rb(), rb());
        case (o)
            7'b0000011: begin
                push(P_ADDR, rb(), rb());
                for (int i = 0; i < mw; i++) push(P_READ, 1'b0, rb());
                push(P_READ, 1'b1, rb());
                push(P_LOADWB, rb(), rb());
            end
            7'b0100011: begin
                push(P_ADDR, rb(), rb());
                for (int i = 0; i < mw; i++) push(P_WRITE, 1'b0, rb());
                push(P_WRITE, 1'b1, rb());
            end
            7'b0110011: begin push(P_EXR, rb(), rb()); push(P_WB, rb(), rb()); end
            7'b0010011: begin push(P_EXI, rb(), rb()); push(P_WB, rb(), rb()); end
            7'b1100011: push(P_BRANCH, rb(), bz);
            7'b1101111: begin push(P_JUMP, rb(), rb()); push(P_WB, rb(), rb()); end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) push(P_TRAP, rb(), rb());
`endif
            end
        endcase
    endtask

    // Reset is asserted while the clock is low and held across a rising edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk({tag, "_rst"}, observed(), expect_of(P_FETCH, op, 1'b0, 1'b0));
        @(negedge clk);
        chk({tag, "_rst_hold"}, observed(), expect_of(P_FETCH, op, 1'b0, 1'b0));
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic run(input string tag, input logic [6:0] o, input int fw,
                       input int mw, input logic bz, input bit abort);
        build(o, fw, mw, bz);
        foreach (q[i]) begin
            @(negedge clk);
            op = o; mem_ready = q[i].mr; zero = q[i].z;
            #1;
            chk($sformatf("%s_c%0d", tag, i), observed(), expect_of(q[i].ph, o, q[i].mr, q[i].z));
        end
        if (abort) begin
            #2;
            do_reset(tag);
        end
`ifdef ILLEGAL_TRAP_EN
        else if (imm_of(o) == 2'b00 && o != 7'b0000011 && o != 7'b0110011 && o != 7'b0010011) begin
            @(negedge clk);
            do_reset({tag, "_trap"});
        end
`endif
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] o;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ops[6] = 7'b1111111;

        rst_n = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk("reset_state", observed(), expect_of(P_FETCH, op, 1'b0, 1'b0));
        @(negedge clk);
        do_reset("init");

        run("rtype",   7'b0110011, 0, 0, 1'b0, 1'b0);
        run("lw_wait", 7'b0000011, 0, 2, 1'b0, 1'b0);
        run("beq_z1",  7'b1100011, 0, 0, 1'b1, 1'b0);
        run("beq_z0",  7'b1100011, 1, 0, 1'b0, 1'b0);
        run("jal",     7'b1101111, 0, 0, 1'b0, 1'b0);
        run("sw",      7'b0100011, 1, 1, 1'b0, 1'b0);
        run("sw_rst",  7'b0100011, 0, 1, 1'b0, 1'b1);
        run("illegal", 7'b1111111, 0, 0, 1'b0, 1'b0);
        run("itype",   7'b0010011, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do o = 7'($urandom);
                while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                       o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111);
            end else begin
                o = ops[$urandom_range(0, 5)];
            end
            run($sformatf("rnd%0d", n), o, $urandom_range(0, 2), $urandom_range(0, 2),
                rb(), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
